uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Buffered 8N1 UART transmitter inside the soc; drives the top-level uart_tx pin that the board wrapper routes to the FPGA pad.
- CPU-side peripheral logic pushes bytes through a valid/ready write port into an internal FIFO.
- A bit-timing FSM serialises the FIFO contents at a fixed baud rate derived from CLK_MHZ, which is 50 on the current board.

Parameters:
- CLK_MHZ, 50, core clock frequency in MHz.
- BAUD, 115200, line rate in bits per second.
- FIFO_DEPTH, 16, number of byte entries; must be a power of two, at least 2.
- Derived localparam DIV = round(CLK_MHZ*1e6/BAUD), which is 434 at the defaults. Must be at least 2.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- wr_valid  in  1  byte offered on wr_data.
- wr_data  in  8  byte to transmit.
- wr_ready  out  1  FIFO can accept a byte; equals !full.
- uart_tx  out  1  serial line, idle high, registered.
- busy  out  1  high while a frame is in flight or the FIFO is non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising clk edge.
- Reset values: uart_tx=1, wr_ready=1, busy=0, fifo_count=0. FSM goes to IDLE and the bit and baud counters clear.
- Reset mid-frame aborts the frame immediately. uart_tx returns high on the reset edge and all FIFO contents are discarded.
- Write handshake: a byte is accepted on any edge where wr_valid && wr_ready. wr_ready is !full only and has no combinational dependence on the pop, so a push offered while full is not accepted even if a pop happens on the same edge.
- Offering a byte while wr_ready=0 is legal: the byte is simply not taken and wr_data may change freely.
- Simultaneous push and pop when the FIFO is non-empty and not full: fifo_count is unchanged and both operations take effect.
- fifo_count increments on push only, decrements on pop only. Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states are IDLE, START, DATA, STOP.
  - Baud counter: counts 0..DIV-1 in START, DATA and STOP.
  - IDLE: when the FIFO is non-empty, pop the head into the shift register, drive uart_tx<=0, go to START, clear the baud counter.
  - START: after DIV cycles, uart_tx<=shift[0], go to DATA with bit index 0.
  - DATA: every DIV cycles, shift right and present the next bit, LSB first. After bit 7 has been held DIV cycles, uart_tx<=1 and go to STOP.
  - STOP: hold uart_tx=1 for DIV cycles. Then, if the FIFO is non-empty, pop, uart_tx<=0 and go to START, giving back-to-back frames with no idle gap. Otherwise go to IDLE.
- Latency: a byte pushed at edge N into an empty FIFO with the FSM in IDLE produces the uart_tx falling edge at edge N+1.
- Frame length is exactly 10*DIV cycles. Each bit is held exactly DIV cycles.
- busy = (state != IDLE) || (fifo_count != 0).
- The FIFO never overflows because of wr_ready gating. It never underflows because a pop happens only when non-empty.

Decomposition:
- Shared package uart_pkg:
  - constants UART_DATA_BITS=8, UART_IDLE_LEVEL=1'b1;
  - typedef uart_state_t enum {IDLE, START, DATA, STOP};
  - function calc_div(clk_mhz, baud) returning the rounded divisor.
- Sub-module sync_fifo (parameters WIDTH, DEPTH): single clock, synchronous active-high reset. Ports push, push_data, pop, pop_data (first-word-fall-through), full, empty, count. It is reusable for a future uart_rx.
- uart_tx_fifo instantiates sync_fifo and contains only the FSM and baud counter.

Test Plan:
- Reset, then idle for 1000 cycles -> uart_tx=1 throughout, busy=0, wr_ready=1, fifo_count=0.
- Push 0x55 at edge N with defaults (DIV=434) -> uart_tx=0 from edge N+1 for 434 cycles. Data bits read 1,0,1,0,1,0,1,0, each 434 cycles, then stop=1. busy drops 4340 cycles after N+1.
- Push 0x41, 0x42, 0x43 on consecutive cycles -> three frames back-to-back, each start bit beginning exactly 4340 cycles after the previous one. A bench UART decoder recovers "ABC".
- Hold wr_valid high with incrementing data for 40 cycles at FIFO_DEPTH=16 -> wr_ready drops once fifo_count=16, exactly 17 bytes accepted (one popped immediately), and the decoded stream is the first 17 values in order.
- Full FIFO with wr_valid held while the STOP-to-START pop occurs -> the offered byte is not accepted that edge and is accepted the next edge. fifo_count goes 16 to 15 to 16.
- Assert rst for 1 cycle midway through data bit 3 of 0xA5 with 5 bytes queued -> uart_tx=1 after that edge, fifo_count=0, busy=0, and no further frame is emitted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, transmitter FSM states and the
// clock-to-baud divisor helper.
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    // Rounded to nearest so the bit period error stays under half a clock.
    function automatic int calc_div(input int clk_mhz, input int baud);
        return (clk_mhz * 1000000 + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; DEPTH must be a power of two.
// Push while full and pop while empty are ignored, so callers need no guards.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: write port into a sync_fifo, drained by a
// bit-timing FSM that emits frames back-to-back while bytes are queued.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_MHZ    = 50,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_valid,
    input  logic [7:0]                  wr_data,
    output logic                        wr_ready,
    output logic                        uart_tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int DIV = calc_div(CLK_MHZ, BAUD);
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

    uart_state_t                 state, state_n;
    logic [CW-1:0]               baud_cnt, baud_cnt_n;
    logic [2:0]                  bit_idx, bit_idx_n;
    logic [UART_DATA_BITS-1:0]   shift, shift_n;
    logic                        tx_q, tx_n;
    logic                        pop;
    logic [UART_DATA_BITS-1:0]   pop_data;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        baud_done;

    // Write handshake: a byte transfers on every rising edge where
    // wr_valid && wr_ready. wr_ready depends only on the registered full flag,
    // so a same-cycle pop never frees room for a push; wr_data may change
    // freely while wr_ready is low.
    assign wr_ready = !fifo_full;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_valid),
        .push_data (wr_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign uart_tx   = tx_q;
    assign busy      = (state != IDLE) || (fifo_count != '0);
    assign baud_done = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_q     <= UART_IDLE_LEVEL;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            shift    <= shift_n;
            tx_q     <= tx_n;
        end
    end

    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt + 1'b1;
        bit_idx_n  = bit_idx;
        shift_n    = shift;
        tx_n       = tx_q;
        pop        = 1'b0;

        unique case (state)
            IDLE: begin
                baud_cnt_n = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = pop_data;
                    tx_n    = 1'b0;
                    state_n = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                    tx_n       = shift[0];
                    state_n    = DATA;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_cnt_n = '0;
                    if (bit_idx == BIT_LAST) begin
                        tx_n    = UART_IDLE_LEVEL;
                        state_n = STOP;
                    end else begin
                        shift_n   = shift >> 1;
                        tx_n      = shift[1];
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_cnt_n = '0;
                    // Chain straight into the next start bit to avoid an idle gap.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_n = pop_data;
                        tx_n    = 1'b0;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo at a short bit period (DIV=8): a
// frame-timeline reference model plus a line decoder feeding a byte scoreboard.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int CLK_MHZ = 2;
    localparam int BAUD    = 250000;
    localparam int DEPTH   = 16;
    localparam int D       = 8;          // 2 MHz / 250 kbaud clocks per bit
    localparam int FRAME   = 10 * D;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready;
    logic       uart_tx;
    logic       busy;
    logic [4:0] fifo_count;

    uart_tx_fifo #(
        .CLK_MHZ    (CLK_MHZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];      // accepted bytes awaiting decode
    logic [7:0] model_q[$];    // reference FIFO contents
    logic [7:0] dec_log[$];
    int         start_times[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // rem = clocks left in the frame on the line; a new frame may start on the
    // edge that ends the previous one (rem==1) or any edge while idle (rem==0).
    int         rem = 0;
    logic [7:0] cur = 8'h00;
    bit         rst_edge = 1'b1;
    bit         can_pop;
    bit         do_push;

    always @(posedge clk) begin
        cyc++;
        rst_edge = rst;
        if (rst) begin
            model_q.delete();
            exp_q.delete();
            rem = 0;
        end else begin
            do_push = wr_valid && (model_q.size() < DEPTH);
            can_pop = (rem <= 1) && (model_q.size() != 0);
            if (can_pop) begin
                cur = model_q.pop_front();
                rem = FRAME;
            end else if (rem != 0) begin
                rem--;
            end
            if (do_push) begin
                model_q.push_back(wr_data);
                exp_q.push_back(wr_data);
            end
        end
    end

    function automatic logic exp_tx();
        int idx;
        if (rem == 0) return 1'b1;
        idx = (FRAME - rem) / D;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return cur[idx-1];
    endfunction

    // ---------------- line decoder / scoreboard ----------------
    bit         dec_active = 1'b0;
    int         dec_cnt = 0;
    int         dec_k;
    logic [7:0] dec_byte = 8'h00;
    logic [31:0] dec_exp;

    always @(negedge clk) begin
        if (rst_edge) begin
            dec_active = 1'b0;
        end else begin
            if (!dec_active && uart_tx === 1'b0) begin
                dec_active = 1'b1;
                dec_cnt = 0;
                start_times.push_back(cyc);
            end
            if (dec_active) begin
                if (dec_cnt % D == D / 2) begin
                    dec_k = dec_cnt / D;
                    if (dec_k == 0) begin
                        check("dec_start_bit", uart_tx, 0);
                    end else if (dec_k <= 8) begin
                        dec_byte[dec_k-1] = uart_tx;
                    end else begin
                        check("dec_stop_bit", uart_tx, 1);
                        dec_exp = (exp_q.size() == 0) ? 32'h100 : 32'(exp_q.pop_front());
                        check("dec_byte", dec_byte, dec_exp);
                        dec_log.push_back(dec_byte);
                        dec_active = 1'b0;
                    end
                end
                dec_cnt++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(negedge clk);
        check("uart_tx", uart_tx, exp_tx());
        check("busy", busy, (rem != 0) || (model_q.size() != 0));
        check("wr_ready", wr_ready, model_q.size() < DEPTH);
        check("fifo_count", fifo_count, model_q.size());
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic push_byte(input logic [7:0] b);
        wr_valid = 1'b1;
        wr_data  = b;
        cycle();
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        for (int k = 0; k < limit; k++) begin
            if (busy === 1'b0) break;
            cycle();
        end
        check("wait_idle_timeout", busy, 0);
    endtask

    // ---------------- directed + random sequence ----------------
    logic [7:0] abc [3] = '{8'h41, 8'h42, 8'h43};
    int n0;
    int s0;
    int acc;
    int m_clk;
    int m_baud;

    initial begin
        m_clk  = 50;
        m_baud = 115200;
        check("calc_div_default", calc_div(m_clk, m_baud), 434);

        // Reset, then a long idle stretch.
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        check("reset_uart_tx", uart_tx, 1);
        check("reset_wr_ready", wr_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_fifo_count", fifo_count, 0);
        run(1000);

        // Single 0x55 frame.
        n0 = dec_log.size();
        push_byte(8'h55);
        check("latency_not_yet_low", uart_tx, 1);
        cycle();
        check("latency_start_low", uart_tx, 0);
        run(FRAME + 4);
        check("single_decoded", dec_log.size(), n0 + 1);
        check("single_value", dec_log[n0], 8'h55);
        check("single_busy_done", busy, 0);

        // Three consecutive pushes give back-to-back frames.
        n0 = dec_log.size();
        s0 = start_times.size();
        wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = abc[i];
            cycle();
        end
        wr_valid = 1'b0;
        run(3 * FRAME + 5);
        check("abc_decoded", dec_log.size(), n0 + 3);
        for (int i = 0; i < 3; i++) check("abc_value", dec_log[n0+i], abc[i]);
        check("abc_gap1", start_times[s0+1] - start_times[s0], FRAME);
        check("abc_gap2", start_times[s0+2] - start_times[s0+1], FRAME);

        // Hold wr_valid for 40 cycles: FIFO fills, one byte already popped.
        n0 = dec_log.size();
        acc = 0;
        wr_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wr_data = 8'(8'h10 + i);
            if (wr_ready === 1'b1) acc++;
            cycle();
        end
        check("burst_accepted", acc, 17);
        check("burst_full_count", fifo_count, 16);
        check("burst_full_ready", wr_ready, 0);

        // Keep offering while full across the STOP-to-START pop.
        wr_data = 8'hEE;
        for (int k = 0; k < 2 * FRAME && fifo_count == 5'd16; k++) cycle();
        check("contend_dip_count", fifo_count, 15);
        check("contend_dip_ready", wr_ready, 1);
        cycle();
        check("contend_refill_count", fifo_count, 16);
        wr_valid = 1'b0;
        wait_idle(20 * FRAME);
        check("burst_decoded", dec_log.size(), n0 + 18);
        for (int i = 0; i < 17; i++) check("burst_order", dec_log[n0+i], 8'(8'h10 + i));
        check("burst_last", dec_log[n0+17], 8'hEE);

        // Reset midway through data bit 3 of 0xA5 with five more queued.
        wr_valid = 1'b1;
        wr_data  = 8'hA5;
        cycle();
        for (int i = 1; i <= 5; i++) begin
            wr_data = 8'(i);
            cycle();
        end
        wr_valid = 1'b0;
        for (int k = 0; k < FRAME && (FRAME - rem) != 4 * D + D / 2 - 1; k++) cycle();
        check("queued_before_reset", fifo_count, 5);
        n0 = dec_log.size();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("abort_uart_tx", uart_tx, 1);
        check("abort_fifo_count", fifo_count, 0);
        check("abort_busy", busy, 0);
        run(4 * FRAME);
        check("abort_no_frames", dec_log.size(), n0);

        // Random traffic, occasionally saturating the FIFO.
        for (int i = 0; i < 400; i++) begin
            wr_valid = ($urandom_range(0, 3) == 0);
            wr_data  = 8'($urandom_range(0, 255));
            cycle();
        end
        wr_valid = 1'b0;
        wait_idle(30 * FRAME);
        run(D);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
